int_ctrl: RTL and testbench

Single-level interrupt controller for the 10-bit-PC CPU. It latches four interrupt request lines and arbitrates them by fixed priority under a software mask. It then sequences the PC stack and the PC mux for entry to a vector and for return from the service routine. It sits between the external request lines, the CPU control unit and the 8-deep return-address stack.

---
 rtl/int_ctrl_pkg.sv | 20 ++
 rtl/int_ctrl_prio_enc4.sv | 21 ++
 rtl/int_ctrl.sv | 140 ++++++++++++++
 tb/tb_int_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: shared constants for the interrupt controller.
//   - FSM state encoding (IDLE, ENTER, SERVICE, RETURN)
//   - PC source select codes driven on pc_sel
//   - PC width of the host CPU
package int_ctrl_pkg;

  localparam int PC_W = 10;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_ENTER   = 2'b01;
  localparam logic [1:0] ST_SERVICE = 2'b10;
  localparam logic [1:0] ST_RETURN  = 2'b11;

  // PC source select
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_VEC = 2'b01;
  localparam logic [1:0] PC_STK = 2'b10;

endpackage

// File: rtl/int_ctrl_prio_enc4.sv
// prio_enc4: combinational fixed-priority encoder.
//   req   in  4  request vector, bit 3 has the highest priority
//   id    out 2  index of the highest set request (0 when none)
//   valid out 1  at least one request is set
module prio_enc4 (
  input  logic [3:0] req,
  output logic [1:0] id,
  output logic       valid
);

  always_comb begin
    id    = 2'd0;
    valid = 1'b1;
    if (req[3])      id = 2'd3;
    else if (req[2]) id = 2'd2;
    else if (req[1]) id = 2'd1;
    else if (req[0]) id = 2'd0;
    else             valid = 1'b0;
  end

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: single-level, four-source interrupt controller.
// Latches rising edges on irq into pending, arbitrates pending & mask (gated
// by gie) by fixed priority, and sequences the return-address stack and PC
// mux for vector entry and return from the service routine.
//   clk        in   system clock (rising edge)
//   reset      in   synchronous active-high reset
//   irq        in   4 request lines, rising-edge sensitive
//   cfg_we     in   load strobe for cfg_mask / cfg_gie
//   cfg_mask   in   per-source enable
//   cfg_gie    in   global enable
//   cpu_ready  in   CPU at an instruction boundary, grants allowed
//   pc_next    in   return address from the datapath
//   reti       in   return-from-interrupt pulse
//   push/pop   out  stack strobes
//   push_data  out  address to push (captured pc_next)
//   pc_sel     out  PC source: 00 seq, 01 vector, 10 stack
//   vector     out  service address of active_id
//   busy       out  ENTER, SERVICE or RETURN
//   active_id  out  source being serviced
//   pending    out  latched requests before masking
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [PC_W-1:0] VEC0 = 10'h3C0,
  parameter logic [PC_W-1:0] VEC1 = 10'h3D0,
  parameter logic [PC_W-1:0] VEC2 = 10'h3E0,
  parameter logic [PC_W-1:0] VEC3 = 10'h3F0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      irq,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_mask,
  input  logic            cfg_gie,
  input  logic            cpu_ready,
  input  logic [PC_W-1:0] pc_next,
  input  logic            reti,
  output logic            push,
  output logic            pop,
  output logic [PC_W-1:0] push_data,
  output logic [1:0]      pc_sel,
  output logic [PC_W-1:0] vector,
  output logic            busy,
  output logic [1:0]      active_id,
  output logic [3:0]      pending
);

  logic [1:0]      state_reg, state_next;
  logic [3:0]      irq_q_reg;
  logic [3:0]      pending_reg, pending_next;
  logic [3:0]      mask_reg;
  logic            gie_reg;
  logic [1:0]      active_id_reg;
  logic [PC_W-1:0] pc_cap_reg;

  logic [3:0] rise;
  logic [3:0] cand;
  logic [1:0] win_id;
  logic       win_valid;
  logic       grant;

  assign rise = irq & ~irq_q_reg;
  assign cand = gie_reg ? (pending_reg & mask_reg) : 4'b0000;

  prio_enc4 u_prio (
    .req   (cand),
    .id    (win_id),
    .valid (win_valid)
  );

  // A grant may also be taken from RETURN so the next ENTER follows with
  // no idle gap; the single nesting level is preserved because the stack
  // has already been popped in that same cycle.
  assign grant = ((state_reg == ST_IDLE) || (state_reg == ST_RETURN)) &&
                 win_valid && cpu_ready;

  // Per-bit pending update: a new rise wins over the grant clear.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pend
      assign pending_next[gi] = rise[gi] |
          (pending_reg[gi] & ~(grant && (win_id == 2'(gi))));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (grant) state_next = ST_ENTER;
      ST_ENTER:   state_next = ST_SERVICE;
      ST_SERVICE: if (reti) state_next = ST_RETURN;
      ST_RETURN:  state_next = grant ? ST_ENTER : ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      irq_q_reg     <= 4'b0000;
      pending_reg   <= 4'b0000;
      mask_reg      <= 4'b0000;
      gie_reg       <= 1'b0;
      active_id_reg <= 2'd0;
      pc_cap_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      irq_q_reg   <= irq;
      pending_reg <= pending_next;
      if (cfg_we) begin
        mask_reg <= cfg_mask;
        gie_reg  <= cfg_gie;
      end
      if (grant) begin
        active_id_reg <= win_id;
        pc_cap_reg    <= pc_next;
      end
    end
  end

  // Outputs decoded from state and registers only.
  always_comb begin
    push   = (state_reg == ST_ENTER);
    pop    = (state_reg == ST_RETURN);
    busy   = (state_reg != ST_IDLE);
    pc_sel = PC_SEQ;
    if (state_reg == ST_ENTER)  pc_sel = PC_VEC;
    if (state_reg == ST_RETURN) pc_sel = PC_STK;
    case (active_id_reg)
      2'd0:    vector = VEC0;
      2'd1:    vector = VEC1;
      2'd2:    vector = VEC2;
      default: vector = VEC3;
    endcase
  end

  assign push_data = pc_cap_reg;
  assign active_id = active_id_reg;
  assign pending   = pending_reg;

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl.
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_int_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq;
  logic       cfg_we;
  logic [3:0] cfg_mask;
  logic       cfg_gie;
  logic       cpu_ready;
  logic [9:0] pc_next;
  logic       reti;
  logic       push, pop, busy;
  logic [9:0] push_data, vector;
  logic [1:0] pc_sel, active_id;
  logic [3:0] pending;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  int_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .cfg_we    (cfg_we),
    .cfg_mask  (cfg_mask),
    .cfg_gie   (cfg_gie),
    .cpu_ready (cpu_ready),
    .pc_next   (pc_next),
    .reti      (reti),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .pc_sel    (pc_sel),
    .vector    (vector),
    .busy      (busy),
    .active_id (active_id),
    .pending   (pending)
  );

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cfg(input logic [3:0] m, input logic g);
    cfg_we = 1'b1; cfg_mask = m; cfg_gie = g;
    tick();
    cfg_we = 1'b0;
  endtask

  // From SERVICE: pulse reti, check RETURN, then return to IDLE.
  task automatic finish_service(input string tag);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check_val({tag, "_ret_pop"}, 32'(pop), 32'd1);
    check_val({tag, "_ret_sel"}, 32'(pc_sel), 32'd2);
    tick();
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; irq = 4'b0; cfg_we = 1'b0; cfg_mask = 4'b0; cfg_gie = 1'b0;
    cpu_ready = 1'b1; pc_next = 10'h000; reti = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_push", 32'(push), 32'd0);
    check_val("rst_pop", 32'(pop), 32'd0);
    check_val("rst_sel", 32'(pc_sel), 32'd0);
    check_val("rst_vec", 32'(vector), 32'h3C0);
    check_val("rst_pdata", 32'(push_data), 32'd0);
    check_val("rst_pend", 32'(pending), 32'd0);

    // Basic entry on irq[1]
    write_cfg(4'b1111, 1'b1);
    pc_next = 10'h055;
    irq = 4'b0010;
    tick();
    check_val("t1_pend", 32'(pending), 32'h2);
    check_val("t1_nobusy", 32'(busy), 32'd0);
    tick();
    irq = 4'b0000;
    check_val("t1_push", 32'(push), 32'd1);
    check_val("t1_pdata", 32'(push_data), 32'h055);
    check_val("t1_sel", 32'(pc_sel), 32'd1);
    check_val("t1_vec", 32'(vector), 32'h3D0);
    check_val("t1_id", 32'(active_id), 32'd1);
    check_val("t1_pclr", 32'(pending), 32'd0);
    tick();
    check_val("t1_svc_push", 32'(push), 32'd0);
    check_val("t1_svc_sel", 32'(pc_sel), 32'd0);
    check_val("t1_svc_busy", 32'(busy), 32'd1);
    finish_service("t1");

    // Simultaneous irq[0] and irq[2]; back-to-back service
    pc_next = 10'h123;
    irq = 4'b0101;
    tick();
    irq = 4'b0000;
    check_val("t2_pend", 32'(pending), 32'h5);
    tick();
    check_val("t2_id", 32'(active_id), 32'd2);
    check_val("t2_vec", 32'(vector), 32'h3E0);
    check_val("t2_pdata", 32'(push_data), 32'h123);
    tick();
    check_val("t2_svc_pend", 32'(pending), 32'h1);
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check_val("t2_ret_pop", 32'(pop), 32'd1);
    check_val("t2_ret_sel", 32'(pc_sel), 32'd2);
    tick();
    check_val("t2_b2b_push", 32'(push), 32'd1);
    check_val("t2_b2b_id", 32'(active_id), 32'd0);
    check_val("t2_b2b_vec", 32'(vector), 32'h3C0);
    check_val("t2_b2b_pend", 32'(pending), 32'd0);
    tick();
    finish_service("t2b");

    // Masked source, then unmask
    write_cfg(4'b0111, 1'b1);
    irq = 4'b1000;
    tick();
    irq = 4'b0000;
    check_val("t3_pend", 32'(pending), 32'h8);
    tick();
    check_val("t3_masked", 32'(busy), 32'd0);
    write_cfg(4'b1111, 1'b1);
    check_val("t3_wr_edge", 32'(busy), 32'd0);
    tick();
    check_val("t3_push", 32'(push), 32'd1);
    check_val("t3_id", 32'(active_id), 32'd3);
    check_val("t3_vec", 32'(vector), 32'h3F0);
    tick();
    finish_service("t3");

    // cpu_ready held low
    cpu_ready = 1'b0;
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val($sformatf("t4_wait%0d", i), 32'(push), 32'd0);
    end
    cpu_ready = 1'b1;
    tick();
    check_val("t4_push", 32'(push), 32'd1);
    check_val("t4_id", 32'(active_id), 32'd0);
    tick();
    finish_service("t4");

    // reti in IDLE is ignored
    reti = 1'b1;
    tick();
    reti = 1'b0;
    check_val("t5_pop", 32'(pop), 32'd0);
    check_val("t5_busy", 32'(busy), 32'd0);
    check_val("t5_sel", 32'(pc_sel), 32'd0);

    // Held level does not retrigger
    irq = 4'b0010;
    tick(); tick();
    check_val("t5_hold_push", 32'(push), 32'd1);
    tick();
    finish_service("t5a");
    for (int i = 0; i < 2; i++) begin
      reti = 1'b1;
      tick();
      reti = 1'b0;
      tick();
      check_val($sformatf("t5_hold_busy%0d", i), 32'(busy), 32'd0);
      check_val($sformatf("t5_hold_pend%0d", i), 32'(pending), 32'd0);
    end
    irq = 4'b0000;
    tick();

    // Reset during SERVICE
    irq = 4'b0100;
    tick();
    irq = 4'b0000;
    tick(); tick();
    check_val("t6_svc_busy", 32'(busy), 32'd1);
    irq = 4'b0001;
    tick();
    irq = 4'b0000;
    check_val("t6_svc_pend", 32'(pending), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_pend", 32'(pending), 32'd0);
    check_val("t6_rst_vec", 32'(vector), 32'h3C0);
    irq = 4'b0010;
    tick();
    irq = 4'b0000;
    check_val("t6_new_pend", 32'(pending), 32'h2);
    tick(); tick();
    check_val("t6_gie_off", 32'(busy), 32'd0);
    write_cfg(4'b1111, 1'b1);
    tick();
    check_val("t6_regrant_push", 32'(push), 32'd1);
    check_val("t6_regrant_id", 32'(active_id), 32'd1);
    tick();
    finish_service("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
